// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, instruction field
// positions and fetch constants.
package fetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;
  localparam int JIDX_HI  = 25;
  localparam int JIDX_LO  = 0;

  localparam int          PC_STEP   = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch bus: the fetch unit is master, instruction memory
// is slave.
interface fetch_unit_if #(
  parameter int PC_W = 8
);

  logic [PC_W-1:0] imem_addr;
  logic            imem_req;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/next_pc_sel.sv
// Next-PC priority mux with branch/jump/register target arithmetic.
// Purely combinational; all arithmetic wraps modulo 2^PC_W.
module next_pc_sel
  import fetch_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0]            i_pc_plus4,
  input  logic [IMM_HI-IMM_LO:0]     i_imm,
  input  logic [JIDX_HI-JIDX_LO:0]   i_jidx,
  input  logic                       i_branch,
  input  logic                       i_jump,
  input  logic                       i_memtopc,
  input  logic                       i_zero,
  input  logic [PC_W-1:0]            i_reg_target,
  output logic [PC_W-1:0]            o_next_pc
);

  logic [31:0]     w_br_off;
  logic [PC_W-1:0] w_br_target;
  logic [PC_W-1:0] w_jmp_target;
  logic [PC_W-1:0] w_jr_target;

  assign w_br_off     = {{14{i_imm[15]}}, i_imm, 2'b00};
  assign w_br_target  = i_pc_plus4 + PC_W'(w_br_off);
  assign w_jmp_target = PC_W'({i_jidx, 2'b00});
  assign w_jr_target  = i_reg_target & ~PC_W'(3);

  // memtopc wins over jump because JR raises both.
  always_comb begin
    // NOTE: default assignment first so every path drives the output and no latch is inferred.
    o_next_pc = i_pc_plus4;
    if (i_memtopc) begin
      o_next_pc = w_jr_target;
    end else if (i_jump) begin
      o_next_pc = w_jmp_target;
    end else if (i_branch && i_zero) begin
      o_next_pc = w_br_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// PC and instruction-fetch stage: requests an instruction, holds it for the
// control unit while executing, then advances the PC.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  fetch_unit_if.master      imem,
  output logic [31:0]       instr,
  output logic              instr_commit,
  output logic [PC_W-1:0]   pc_plus4,
  input  logic              branch,
  input  logic              jump,
  input  logic              memtopc,
  input  logic              zero,
  input  logic [PC_W-1:0]   reg_target,
  input  logic              stall,
  output logic [15:0]       commit_count
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_next_pc;
  logic [31:0]     r_instr;
  logic [15:0]     r_commit_count;
  logic            w_latch;
  logic            w_advance;

  assign pc_plus4 = r_pc + PC_W'(PC_STEP);

  next_pc_sel #(.PC_W(PC_W)) u_next_pc_sel (
    .i_pc_plus4   (pc_plus4),
    .i_imm        (r_instr[IMM_HI:IMM_LO]),
    .i_jidx       (r_instr[JIDX_HI:JIDX_LO]),
    .i_branch     (branch),
    .i_jump       (jump),
    .i_memtopc    (memtopc),
    .i_zero       (zero),
    .i_reg_target (reg_target),
    .o_next_pc    (w_next_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FETCH;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      FETCH: begin
        if (imem.imem_ack) begin
          w_latch     = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
          w_advance   = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      default: w_state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc           <= PC_W'(RESET_PC);
      r_instr        <= NOP_INSTR;
      r_commit_count <= '0;
    end else begin
      if (w_latch) begin
        r_instr <= imem.imem_rdata;
      end
      if (w_advance) begin
        r_pc           <= w_next_pc;
        r_commit_count <= r_commit_count + 16'd1;
      end
    end
  end

  // rst gates the request and commit so they drop before the async reset settles.
  assign imem.imem_addr = r_pc;
  assign imem.imem_req  = !rst && (r_state == FETCH);
  assign instr_commit   = !rst && (r_state == EXEC) && !stall;
  assign instr          = r_instr;
  assign commit_count   = r_commit_count;

endmodule
